// File: rtl/vga_timing_monitor.sv
// Receive-side checker for a VGA hsync/vsync pair: measures line/frame
// timing, runs a lock state machine and counts timing faults.
module vga_timing_monitor #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_PERIOD_EXP    = 3200,
  parameter int H_TOL           = 4,
  parameter int V_LINES_EXP     = 525,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hSync,
  input  logic        vSync,
  output logic [12:0] h_period,
  output logic [12:0] h_sync_width,
  output logic [9:0]  v_lines,
  output logic [9:0]  v_sync_lines,
  output logic        locked,
  output logic        frame_tick,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [12:0] H_EXP = 13'(H_PERIOD_EXP);
  localparam logic [12:0] H_TO  = 13'(2 * H_PERIOD_EXP);
  localparam logic [12:0] H_TL  = 13'(H_TOL);
  localparam logic [9:0]  V_EXP = 10'(V_LINES_EXP);
  localparam logic [3:0]  LK    = 4'(LOCK_FRAMES);

  state_t      r_state, w_state_n;
  logic [3:0]  r_good, w_good_n;
  logic        r_hs, r_hs_d, r_vs, r_vs_d;
  logic [12:0] r_hcnt, r_wcnt;
  logic [9:0]  r_vcnt, r_vscnt;
  logic        r_first, r_line_err;
  logic        w_hlead, w_htrail, w_vlead, w_vtrail;
  logic [12:0] w_hdiff;
  logic        w_hbad, w_timeout, w_frame_good;
  logic        w_err_inc, w_tick, w_to_search;

  assign w_hlead  = r_hs & ~r_hs_d;
  assign w_htrail = ~r_hs & r_hs_d;
  assign w_vlead  = r_vs & ~r_vs_d;
  assign w_vtrail = ~r_vs & r_vs_d;

  // r_hcnt holds the cycles elapsed since the last leading edge
  assign w_hdiff = (r_hcnt >= H_EXP) ? r_hcnt - H_EXP
                                     : H_EXP - r_hcnt;
  assign w_hbad       = w_hdiff > H_TL;
  assign w_timeout    = ~w_hlead & (r_hcnt == H_TO);
  assign w_frame_good = (r_vcnt == V_EXP) & ~r_line_err;
  assign w_to_search  = (w_state_n == SEARCH) & (r_state != SEARCH);
  assign locked       = (r_state == LOCKED);

  always_comb begin
    w_state_n = r_state;
    w_good_n  = r_good;
    w_err_inc = 1'b0;
    w_tick    = 1'b0;
    if (w_timeout) begin
      w_state_n = SEARCH;
      w_good_n  = 4'd0;
      w_err_inc = (r_state == LOCKED);
    end else if (w_vlead) begin
      unique case (1'b1)
        (r_state == SEARCH): begin
          w_state_n = ACQUIRE;
          w_good_n  = 4'd0;
        end
        (r_state == ACQUIRE): begin
          if (!w_frame_good) begin
            w_good_n = 4'd0;
          end else if (r_good + 4'd1 >= LK) begin
            w_state_n = LOCKED;
            w_good_n  = 4'd0;
          end else begin
            w_good_n = r_good + 4'd1;
          end
        end
        (r_state == LOCKED): begin
          if (w_frame_good) begin
            w_tick = 1'b1;
          end else begin
            w_state_n = SEARCH;
            w_err_inc = 1'b1;
          end
        end
        default: begin
          w_state_n = SEARCH;
          w_good_n  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEARCH;
      r_good  <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_good  <= w_good_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs         <= 1'b0;
      r_hs_d       <= 1'b0;
      r_vs         <= 1'b0;
      r_vs_d       <= 1'b0;
      r_hcnt       <= 13'd0;
      r_wcnt       <= 13'd0;
      r_vcnt       <= 10'd0;
      r_vscnt      <= 10'd0;
      r_first      <= 1'b0;
      r_line_err   <= 1'b0;
      h_period     <= 13'd0;
      h_sync_width <= 13'd0;
      v_lines      <= 10'd0;
      v_sync_lines <= 10'd0;
      frame_tick   <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      r_hs       <= hSync ^ SYNC_ACTIVE_LOW;
      r_hs_d     <= r_hs;
      r_vs       <= vSync ^ SYNC_ACTIVE_LOW;
      r_vs_d     <= r_vs;
      frame_tick <= w_tick;

      if (w_hlead)
        r_hcnt <= 13'd1;
      else if (r_hcnt != '1)
        r_hcnt <= r_hcnt + 13'd1;
      if (w_hlead & r_first)
        h_period <= r_hcnt;

      if (w_hlead)
        r_wcnt <= 13'd1;
      else if (r_hs && r_wcnt != '1)
        r_wcnt <= r_wcnt + 13'd1;
      if (w_htrail)
        h_sync_width <= r_wcnt;

      if (w_hlead)
        r_first <= 1'b1;
      else if (w_timeout | w_to_search)
        r_first <= 1'b0;

      // a line coincident with vsync belongs to the new frame
      r_line_err <= (r_line_err & ~w_vlead)
                  | (w_hlead & r_first & w_hbad);

      if (w_vlead)
        v_lines <= r_vcnt;
      if (w_timeout)
        r_vcnt <= 10'd0;
      else if (w_vlead)
        r_vcnt <= {9'd0, w_hlead};
      else if (w_hlead && r_vcnt != '1)
        r_vcnt <= r_vcnt + 10'd1;

      if (w_vtrail)
        v_sync_lines <= r_vscnt;
      if (w_vlead)
        r_vscnt <= {9'd0, w_hlead};
      else if (r_vs && w_hlead && r_vscnt != '1)
        r_vscnt <= r_vscnt + 10'd1;

      if (w_err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
